// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
//
// Receive-side decoder for a multiplexed, active-low, anode-scanned
// seven-segment display bus.  The bus is sampled every clock.  Once an
// {anode, segment} pattern has been held for STABLE_CYCLES consecutive
// samples, and exactly one anode is active, the segment pattern is decoded
// back to a BCD nibble and stored in that anode's digit slot.  When every
// slot has been captured since the last frame, frame_valid pulses for a
// single cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   an           anode enables, active-low (an[i]=0 selects slot i)
//   seg          segment lines {g,f,e,d,c,b,a}, active-low
//   digits_out   decoded digits, slot i at [4i+3:4i]
//   blank        slot i last captured as all segments off
//   digit_err    slot i last captured as a non-decodable pattern
//   frame_valid  one-cycle pulse when all slots captured since last frame
// -----------------------------------------------------------------------------
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ALL     = {NUM_DIGITS{1'b1}};

    // Decoded result: {err, blank, nibble}
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        logic [5:0] r;
        case (pat)
            7'b1000000: r = {2'b00, 4'd0};
            7'b1111001: r = {2'b00, 4'd1};
            7'b0100100: r = {2'b00, 4'd2};
            7'b0110000: r = {2'b00, 4'd3};
            7'b0011001: r = {2'b00, 4'd4};
            7'b0010010: r = {2'b00, 4'd5};
            7'b0000010: r = {2'b00, 4'd6};
            7'b1111000: r = {2'b00, 4'd7};
            7'b0000000: r = {2'b00, 4'd8};
            7'b0010000: r = {2'b00, 4'd9};
            7'b1111111: r = {2'b01, 4'hF};
            default:    r = {2'b10, 4'hE};
        endcase
        return r;
    endfunction

    logic [NUM_DIGITS-1:0] s_an;
    logic [6:0]            s_seg;
    logic [CNT_W-1:0]      cnt;
    logic                  captured;
    logic [NUM_DIGITS-1:0] mask;

    logic                  same;
    logic                  one_low;
    logic [NUM_DIGITS-1:0] an_inv;
    logic [SLOT_W-1:0]     slot;
    logic                  capture;
    logic [5:0]            dec;
    logic [NUM_DIGITS-1:0] mask_next;

    assign same   = ({an, seg} == {s_an, s_seg});
    assign an_inv = ~an;
    // Exactly one active anode: non-zero and a power of two.
    assign one_low = (an_inv != '0) && ((an_inv & (an_inv - ONE)) == '0);
    assign capture = same && (cnt == CNT_MAX) && !captured && one_low;
    assign dec     = decode_seg(s_seg);
    assign mask_next = mask | (ONE << slot);

    always_comb begin
        slot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) slot = SLOT_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_an        <= ALL;
            s_seg       <= 7'h7F;
            cnt         <= '0;
            captured    <= 1'b0;
            mask        <= '0;
            digits_out  <= {4*NUM_DIGITS{1'b1}};
            blank       <= ALL;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            s_an        <= an;
            s_seg       <= seg;
            frame_valid <= 1'b0;

            // Stability tracking: any change restarts the count and re-arms capture.
            if (!same) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (capture) begin
                digits_out[4*slot +: 4] <= dec[3:0];
                blank[slot]             <= dec[4];
                digit_err[slot]         <= dec[5];
                captured                <= 1'b1;
                // Completing the mask ends the frame and starts a fresh one.
                if (mask_next == ALL) begin
                    frame_valid <= 1'b1;
                    mask        <= '0;
                end else begin
                    mask <= mask_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0] blank;
    logic [ND-1:0] digit_err;
    logic          frame_valid;

    int tests = 0;
    int fails = 0;
    int fv_count = 0;

    seg_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
        .digits_out(digits_out), .blank(blank), .digit_err(digit_err),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    logic [3:0]  m_dig [ND];
    logic [ND-1:0] m_blank, m_err, m_mask;
    logic        m_fv;
    logic [ND+6:0] m_prev;
    int          m_run;
    bit          m_ok = 0;

    // A pattern seen for the first time on edge 1 is captured on edge SC+1,
    // provided exactly one anode is low; otherwise never while it persists.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ND; i++) m_dig[i] = 4'hF;
            m_blank = '1; m_err = '0; m_mask = '0; m_fv = 0;
            m_prev = '1; m_run = 1; m_ok = 1;
        end else if (m_ok) begin
            int k, lows;
            m_fv = 0;
            if ({an, seg} == m_prev) m_run = m_run + 1;
            else m_run = 1;
            lows = 0; k = 0;
            for (int i = 0; i < ND; i++) if (!m_prev[7+i]) begin lows++; k = i; end
            if (m_run == SC + 1 && lows == 1) begin
                int d;
                d = -1;
                for (int j = 0; j < 10; j++) if (m_prev[6:0] == pat_tab[j]) d = j;
                if (d >= 0) begin
                    m_dig[k] = 4'(d); m_blank[k] = 0; m_err[k] = 0;
                end else if (m_prev[6:0] == 7'h7F) begin
                    m_dig[k] = 4'hF; m_blank[k] = 1; m_err[k] = 0;
                end else begin
                    m_dig[k] = 4'hE; m_blank[k] = 0; m_err[k] = 1;
                end
                m_mask[k] = 1;
                if (m_mask == '1) begin m_fv = 1; m_mask = '0; end
            end
            m_prev = {an, seg};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_count++;
        if (m_ok) begin
            logic [4*ND-1:0] exp_d;
            for (int i = 0; i < ND; i++) exp_d[4*i +: 4] = m_dig[i];
            tests++;
            if (digits_out !== exp_d) begin
                fails++; $display("FAIL digits_out: got %h expected %h at %0t", digits_out, exp_d, $time);
            end
            tests++;
            if (blank !== m_blank) begin
                fails++; $display("FAIL blank: got %b expected %b at %0t", blank, m_blank, $time);
            end
            tests++;
            if (digit_err !== m_err) begin
                fails++; $display("FAIL digit_err: got %b expected %b at %0t", digit_err, m_err, $time);
            end
            tests++;
            if (frame_valid !== m_fv) begin
                fails++; $display("FAIL frame_valid: got %b expected %b at %0t", frame_valid, m_fv, $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold(input logic [ND-1:0] a, input logic [6:0] s, input int n);
        an = a; seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 0; an = '1; seg = 7'h7F;
        repeat (n) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int fv0;
        rst_n = 0; an = '1; seg = 7'h7F;
        do_reset(2);
        check("reset_digits", 32'(digits_out), 32'hFFFF);
        check("reset_blank", 32'(blank), 32'hF);
        check("reset_err", 32'(digit_err), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);

        // Full scan 1,2,3,4; frame pulse lands on edge 5 of the 4th hold.
        fv0 = fv_count;
        hold(4'b1110, 7'b1111001, 8);
        hold(4'b1101, 7'b0100100, 8);
        hold(4'b1011, 7'b0110000, 8);
        hold(4'b0111, 7'b0011001, 4);
        check("scan_fv_before_edge5", 32'(fv_count - fv0), 32'd0);
        hold(4'b0111, 7'b0011001, 1);
        check("scan_fv_at_edge5", 32'(frame_valid), 32'd1);
        hold(4'b0111, 7'b0011001, 3);
        check("scan_digits", 32'(digits_out), 32'h4321);
        check("scan_blank", 32'(blank), 32'h0);
        check("scan_err", 32'(digit_err), 32'h0);
        check("scan_fv_count", 32'(fv_count - fv0), 32'd1);

        // Glitch shorter than the stability window.
        fv0 = fv_count;
        hold(4'b1110, 7'b0000000, 2);
        hold(4'b1111, 7'h7F, 8);
        check("glitch_slot0", 32'(digits_out[3:0]), 32'h1);
        check("glitch_fv", 32'(fv_count - fv0), 32'd0);

        // Digit, blank, error and digit patterns.
        fv0 = fv_count;
        hold(4'b1110, 7'b1111000, 8);
        hold(4'b1101, 7'b1111111, 8);
        hold(4'b1011, 7'b1010101, 8);
        hold(4'b0111, 7'b1000000, 8);
        check("bad_digits", 32'(digits_out), 32'h0EF7);
        check("bad_blank", 32'(blank), 32'b0010);
        check("bad_err", 32'(digit_err), 32'b0100);
        check("bad_fv_count", 32'(fv_count - fv0), 32'd1);

        // Ghosting: two anodes low never captures.
        fv0 = fv_count;
        hold(4'b1100, 7'b1111000, 10);
        check("ghost_digits", 32'(digits_out), 32'h0EF7);
        check("ghost_fv", 32'(fv_count - fv0), 32'd0);
        hold(4'b1110, 7'b0010010, 8);
        hold(4'b1101, 7'b0000010, 8);
        hold(4'b1011, 7'b0000000, 8);
        hold(4'b0111, 7'b0010000, 8);
        check("ghost_then_scan_fv", 32'(fv_count - fv0), 32'd1);
        check("ghost_then_scan_digits", 32'(digits_out), 32'h9865);

        // Reset in the middle of a frame discards the partial mask.
        fv0 = fv_count;
        hold(4'b1110, 7'b0010010, 8);
        hold(4'b1101, 7'b0000010, 8);
        do_reset(1);
        hold(4'b1011, 7'b0000000, 8);
        hold(4'b0111, 7'b0010000, 8);
        check("midrst_fv", 32'(fv_count - fv0), 32'd0);
        check("midrst_digits", 32'(digits_out), 32'h98FF);
        hold(4'b1110, 7'b1111001, 8);
        hold(4'b1101, 7'b0100100, 8);
        check("midrst_recapture_fv", 32'(fv_count - fv0), 32'd1);

        // Randomised scan traffic, checked every cycle by the model.
        for (int n = 0; n < 400; n++) begin
            logic [ND-1:0] a;
            logic [6:0] s;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) a = ~(4'b0001 << $urandom_range(0, ND - 1));
            else if (r == 7) a = '1;
            else a = 4'($urandom);
            r = int'($urandom_range(0, 11));
            if (r < 10) s = pat_tab[r];
            else if (r == 10) s = 7'h7F;
            else s = 7'($urandom);
            if ($urandom_range(0, 49) == 0) do_reset(1);
            hold(a, s, int'($urandom_range(1, 9)));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
